register_file_banked: RTL and testbench
=======================================

Name: register_file_banked

Overview:
Parametrised successor to the 16-entry, 3-read/1-write ARM register file used by the datapath. Adds:
- a second write port for base-register writeback;
- R13/R14 banked per processor mode;
- a registered PC-load strobe when an instruction writes R15.

Reads remain combinational for the decode/operand stage. Writes commit on the rising CLK edge.

Parameters:
ADDR_WIDTH, 4, register index width; 2**ADDR_WIDTH architectural registers (minimum 4).
DATA_WIDTH, 32, register and port data width.
PC_INDEX, 15, index whose read returns PROGCOUNT and whose write raises PC_LD.
NUM_MODES, 4, number of R13/R14 banks (User=0, IRQ=1, SVC=2, ABT=3).

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
RA  input  ADDR_WIDTH  read address, port A.
RB  input  ADDR_WIDTH  read address, port B.
RC  input  ADDR_WIDTH  read address, port C.
PA  output  DATA_WIDTH  read data, port A.
PB  output  DATA_WIDTH  read data, port B.
PC  output  DATA_WIDTH  read data, port C.
RW  input  ADDR_WIDTH  write address, port 0 (ALU/load result).
PW  input  DATA_WIDTH  write data, port 0.
LE  input  1  write enable, port 0.
RW2  input  ADDR_WIDTH  write address, port 1 (base writeback).
PW2  input  DATA_WIDTH  write data, port 1.
LE2  input  1  write enable, port 1.
MODE  input  clog2(NUM_MODES)  current mode; selects the R13/R14 bank for reads and writes.
PROGCOUNT  input  DATA_WIDTH  current PC value; returned on reads of PC_INDEX.
PC_LD  output  1  registered strobe: R15 was written on the previous edge.
PC_NEXT  output  DATA_WIDTH  registered data accompanying PC_LD.

Behaviour:
- Storage:
  - unbanked entries for all indices except 13, 14 and PC_INDEX;
  - NUM_MODES copies each of R13 and R14;
  - no storage for PC_INDEX.
- Reset (RST high, asynchronous): all storage is cleared to 0, including every bank; PC_LD=0; PC_NEXT=0. After reset, PA/PB/PC read 0 for any index other than PC_INDEX.
- Reads (combinational, zero latency):
  - addr==PC_INDEX -> PROGCOUNT.
  - addr 13 or 14 -> the bank selected by the current MODE.
  - otherwise -> the unbanked entry.
- Writes, on the rising CLK edge with RST low:
  - port 0 writes when LE=1; port 1 writes when LE2=1;
  - banked targets use the MODE value sampled at that edge.
- Write conflict: both ports enabled with RW==RW2 -> port 0 (PW) wins; port 1's write to that index is dropped.
- Writes to PC_INDEX do not touch storage. On that edge PC_LD<=1 and PC_NEXT<=write data, using PW if port 0 targets PC_INDEX, else PW2.
  - PC_LD is high for exactly one cycle unless another PC_INDEX write occurs on the next edge.
  - With no PC write on an edge: PC_LD<=0 and PC_NEXT holds its value.
- Read-during-write, bypass disabled: a read of the index being written returns the old value until after the edge.
- MODE change: takes effect on reads immediately (combinational). Bank contents of the other modes are preserved.
- MODE value >= NUM_MODES: the access is treated as bank 0 (User).
- Address wrap-around: indices are naturally modulo 2**ADDR_WIDTH; no out-of-range case exists.
- RST asserted mid-cycle: outputs clear immediately; any write on a concurrent edge is lost.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read whose address matches an enabled write port that cycle (same bank for 13/14, non-PC index) returns that port's write data combinationally. Port 0 takes priority over port 1, consistent with the write-conflict rule. Reads of PC_INDEX still return PROGCOUNT.
- Undefined: reads return stored values only; no forwarding logic is synthesised.

Decomposition:
- Shared include register_file_pkg.vh:
  - SP_INDEX=13, LR_INDEX=14, PC_INDEX_DEFAULT=15;
  - mode encodings MODE_USR/IRQ/SVC/ABT;
  - MODE width constant.
- One natural sub-module, regfile_read_mux:
  - one instance per read port (three total);
  - inputs: address, MODE, PROGCOUNT, storage and bank vectors, optional bypass inputs;
  - output: read data.
- Write decode, conflict resolution and PC_LD logic stay in the top module.

Test Plan:
- Reset, then RA=3, RB=13, RC=15 with PROGCOUNT=32 -> PA=0, PB=0, PC=32, PC_LD=0.
- LE=1, RW=5, PW=20 for one edge; then RA=5 -> PA=20. Re-check after a second RST pulse -> PA=0.
- Banking:
  - MODE=0, write R13=100;
  - MODE=2, write R13=200;
  - read RB=13 -> 200; switch MODE=0 -> RB reads 100 with no clock edge.
- Conflict and PC load:
  - LE=LE2=1, RW=RW2=7, PW=11, PW2=22 -> R7=11 after the edge.
  - LE=1, RW=15, PW=64 -> next cycle PC_LD=1, PC_NEXT=64; the cycle after, PC_LD=0; RA=15 still reads PROGCOUNT.
- Sweep RW/RA 0..14 with PW=20+i and RB=(RA+1)%16, RC=(RA+2)%16, one write per edge -> each register reads back 20+i; reads of 13/14 reflect the MODE used at the write edge.
- With REGFILE_WRITE_BYPASS_EN: LE=1, RW=RA=9, PW=0xDEAD -> PA=0xDEAD before the edge. Without the macro -> PA=old value (0) before the edge, 0xDEAD after it.

Source files
------------

// File: rtl/register_file_banked_pkg.sv
// Shared constants for the banked ARM register file: fixed SP/LR indices,
// default PC index, processor mode encodings and a mode-width helper.
package register_file_banked_pkg;

    localparam int SP_INDEX         = 13;
    localparam int LR_INDEX         = 14;
    localparam int PC_INDEX_DEFAULT = 15;
    localparam int MODE_W           = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_USR = 2'd0,
        MODE_IRQ = 2'd1,
        MODE_SVC = 2'd2,
        MODE_ABT = 2'd3
    } mode_e;

    // Width of the MODE bus; never narrower than one bit.
    function automatic int mode_bits(input int num_modes);
        return (num_modes > 1) ? $clog2(num_modes) : 1;
    endfunction

endpackage

// File: rtl/register_file_banked_read_mux.sv
// One combinational read port of the banked register file.
// With REGFILE_WRITE_BYPASS_EN defined, same-cycle write data is forwarded.
module register_file_banked_read_mux
    import register_file_banked_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PC_INDEX   = PC_INDEX_DEFAULT,
    parameter int NUM_MODES  = 4
) (
    input  logic [ADDR_WIDTH-1:0]                      i_addr,
    input  logic [mode_bits(NUM_MODES)-1:0]            i_bank,
    input  logic [DATA_WIDTH-1:0]                      i_progcount,
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] i_regs,
    input  logic [NUM_MODES-1:0][DATA_WIDTH-1:0]       i_sp,
    input  logic [NUM_MODES-1:0][DATA_WIDTH-1:0]       i_lr,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                                       i_we0,
    input  logic [ADDR_WIDTH-1:0]                      i_wa0,
    input  logic [DATA_WIDTH-1:0]                      i_wd0,
    input  logic                                       i_we1,
    input  logic [ADDR_WIDTH-1:0]                      i_wa1,
    input  logic [DATA_WIDTH-1:0]                      i_wd1,
`endif
    output logic [DATA_WIDTH-1:0]                      o_data
);

    localparam logic [ADDR_WIDTH-1:0] A_SP = ADDR_WIDTH'(SP_INDEX);
    localparam logic [ADDR_WIDTH-1:0] A_LR = ADDR_WIDTH'(LR_INDEX);
    localparam logic [ADDR_WIDTH-1:0] A_PC = ADDR_WIDTH'(PC_INDEX);

    always_comb begin
        o_data = i_regs[i_addr];
        if (i_addr == A_SP) begin
            o_data = i_sp[i_bank];
        end else if (i_addr == A_LR) begin
            o_data = i_lr[i_bank];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        // Port 1 first so port 0 overrides it on a shared address.
        if (i_we1 && (i_wa1 == i_addr)) begin
            o_data = i_wd1;
        end
        if (i_we0 && (i_wa0 == i_addr)) begin
            o_data = i_wd0;
        end
`endif
        if (i_addr == A_PC) begin
            o_data = i_progcount;
        end
    end

endmodule

// File: rtl/register_file_banked.sv
// Banked 3-read/2-write ARM register file with R13/R14 per mode and a
// registered PC-load strobe. Optional forwarding: REGFILE_WRITE_BYPASS_EN.
module register_file_banked
    import register_file_banked_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PC_INDEX   = PC_INDEX_DEFAULT,
    parameter int NUM_MODES  = 4
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [ADDR_WIDTH-1:0]           RA,
    input  logic [ADDR_WIDTH-1:0]           RB,
    input  logic [ADDR_WIDTH-1:0]           RC,
    output logic [DATA_WIDTH-1:0]           PA,
    output logic [DATA_WIDTH-1:0]           PB,
    output logic [DATA_WIDTH-1:0]           PC,
    input  logic [ADDR_WIDTH-1:0]           RW,
    input  logic [DATA_WIDTH-1:0]           PW,
    input  logic                            LE,
    input  logic [ADDR_WIDTH-1:0]           RW2,
    input  logic [DATA_WIDTH-1:0]           PW2,
    input  logic                            LE2,
    input  logic [mode_bits(NUM_MODES)-1:0] MODE,
    input  logic [DATA_WIDTH-1:0]           PROGCOUNT,
    output logic                            PC_LD,
    output logic [DATA_WIDTH-1:0]           PC_NEXT
);

    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int MW   = mode_bits(NUM_MODES);
    localparam logic [ADDR_WIDTH-1:0] A_SP = ADDR_WIDTH'(SP_INDEX);
    localparam logic [ADDR_WIDTH-1:0] A_LR = ADDR_WIDTH'(LR_INDEX);
    localparam logic [ADDR_WIDTH-1:0] A_PC = ADDR_WIDTH'(PC_INDEX);

    // Entries at SP/LR/PC indices are never written and reduce to constants.
    logic [NREG-1:0][DATA_WIDTH-1:0]      r_regs;
    logic [NUM_MODES-1:0][DATA_WIDTH-1:0] r_sp;
    logic [NUM_MODES-1:0][DATA_WIDTH-1:0] r_lr;
    logic                                 r_pc_ld;
    logic [DATA_WIDTH-1:0]                r_pc_next;

    logic [MW-1:0] w_bank;
    logic          w_wr0;
    logic          w_wr1;
    logic          w_pc0;
    logic          w_pc1;

    // Out-of-range modes fall back to the User bank.
    assign w_bank = (int'(MODE) < NUM_MODES) ? MODE : '0;

    assign w_pc0 = LE  && (RW  == A_PC);
    assign w_pc1 = LE2 && (RW2 == A_PC);
    assign w_wr0 = LE  && (RW  != A_PC);
    assign w_wr1 = LE2 && (RW2 != A_PC) && !(LE && (RW == RW2));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_regs    <= '0;
            r_sp      <= '0;
            r_lr      <= '0;
            r_pc_ld   <= 1'b0;
            r_pc_next <= '0;
        end else begin
            if (w_wr1) begin
                if (RW2 == A_SP)      r_sp[w_bank] <= PW2;
                else if (RW2 == A_LR) r_lr[w_bank] <= PW2;
                else                  r_regs[RW2]  <= PW2;
            end
            if (w_wr0) begin
                if (RW == A_SP)      r_sp[w_bank] <= PW;
                else if (RW == A_LR) r_lr[w_bank] <= PW;
                else                 r_regs[RW]   <= PW;
            end
            r_pc_ld <= w_pc0 || w_pc1;
            if (w_pc0)      r_pc_next <= PW;
            else if (w_pc1) r_pc_next <= PW2;
        end
    end

    assign PC_LD   = r_pc_ld;
    assign PC_NEXT = r_pc_next;

    register_file_banked_read_mux #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .PC_INDEX(PC_INDEX), .NUM_MODES(NUM_MODES)
    ) u_rd_a (
        .i_addr(RA), .i_bank(w_bank), .i_progcount(PROGCOUNT),
        .i_regs(r_regs), .i_sp(r_sp), .i_lr(r_lr),
`ifdef REGFILE_WRITE_BYPASS_EN
        .i_we0(LE), .i_wa0(RW), .i_wd0(PW),
        .i_we1(LE2), .i_wa1(RW2), .i_wd1(PW2),
`endif
        .o_data(PA)
    );

    register_file_banked_read_mux #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .PC_INDEX(PC_INDEX), .NUM_MODES(NUM_MODES)
    ) u_rd_b (
        .i_addr(RB), .i_bank(w_bank), .i_progcount(PROGCOUNT),
        .i_regs(r_regs), .i_sp(r_sp), .i_lr(r_lr),
`ifdef REGFILE_WRITE_BYPASS_EN
        .i_we0(LE), .i_wa0(RW), .i_wd0(PW),
        .i_we1(LE2), .i_wa1(RW2), .i_wd1(PW2),
`endif
        .o_data(PB)
    );

    register_file_banked_read_mux #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .PC_INDEX(PC_INDEX), .NUM_MODES(NUM_MODES)
    ) u_rd_c (
        .i_addr(RC), .i_bank(w_bank), .i_progcount(PROGCOUNT),
        .i_regs(r_regs), .i_sp(r_sp), .i_lr(r_lr),
`ifdef REGFILE_WRITE_BYPASS_EN
        .i_we0(LE), .i_wa0(RW), .i_wd0(PW),
        .i_we1(LE2), .i_wa1(RW2), .i_wd1(PW2),
`endif
        .o_data(PC)
    );

endmodule

// File: tb/tb_register_file_banked.sv
// Randomised, model-checked bench for register_file_banked.
// Builds with or without REGFILE_WRITE_BYPASS_EN.
module tb_register_file_banked;
    import register_file_banked_pkg::*;

    localparam int NM = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  RA, RB, RC, RW, RW2;
    logic [31:0] PA, PB, PC, PW, PW2, PROGCOUNT, PC_NEXT;
    logic        LE, LE2, PC_LD;
    logic [1:0]  MODE;

    int errors = 0;
    int checks = 0;

    // Architectural model: plain arrays indexed by register number and bank.
    logic [31:0] m_regs [16];
    logic [31:0] m_sp   [NM];
    logic [31:0] m_lr   [NM];
    logic        m_pc_ld;
    logic [31:0] m_pc_next;

    always #5 CLK = ~CLK;

    register_file_banked dut (
        .CLK(CLK), .RST(RST),
        .RA(RA), .RB(RB), .RC(RC),
        .PA(PA), .PB(PB), .PC(PC),
        .RW(RW), .PW(PW), .LE(LE),
        .RW2(RW2), .PW2(PW2), .LE2(LE2),
        .MODE(MODE), .PROGCOUNT(PROGCOUNT),
        .PC_LD(PC_LD), .PC_NEXT(PC_NEXT)
    );

    function automatic int cur_bank();
        return (int'(MODE) < NM) ? int'(MODE) : 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a == 4'd15) return PROGCOUNT;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (LE && RW == a) return PW;
        if (LE2 && RW2 == a) return PW2;
`endif
        if (a == 4'd13) return m_sp[cur_bank()];
        if (a == 4'd14) return m_lr[cur_bank()];
        return m_regs[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        for (int i = 0; i < NM; i++) begin
            m_sp[i] = '0;
            m_lr[i] = '0;
        end
        m_pc_ld   = 1'b0;
        m_pc_next = '0;
    endtask

    task automatic model_store(input logic [3:0] a, input logic [31:0] d, input int b);
        if (a == 4'd13)      m_sp[b] = d;
        else if (a == 4'd14) m_lr[b] = d;
        else if (a != 4'd15) m_regs[a] = d;
    endtask

    task automatic model_edge();
        int b;
        b = cur_bank();
        if (LE2 && !(LE && RW == RW2)) model_store(RW2, PW2, b);
        if (LE) model_store(RW, PW, b);
        if (LE && RW == 4'd15) begin
            m_pc_ld = 1'b1; m_pc_next = PW;
        end else if (LE2 && RW2 == 4'd15) begin
            m_pc_ld = 1'b1; m_pc_next = PW2;
        end else begin
            m_pc_ld = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        LE = 0; LE2 = 0; RW = 0; RW2 = 0; PW = 0; PW2 = 0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        MODE = 2'd0; PROGCOUNT = 32'd32;
        RA = 4'd3; RB = 4'd13; RC = 4'd15;
        model_reset();
        #12;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if (PA !== 32'd0) begin errors++; $display("FAIL reset_pa got %h want %h", PA, 32'd0); end
        checks++; if (PB !== 32'd0) begin errors++; $display("FAIL reset_pb got %h want %h", PB, 32'd0); end
        checks++; if (PC !== 32'd32) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'd32); end
        checks++; if (PC_LD !== 1'b0) begin errors++; $display("FAIL reset_pc_ld got %b want 0", PC_LD); end
        checks++; if (PC_NEXT !== 32'd0) begin errors++; $display("FAIL reset_pc_next got %h want 0", PC_NEXT); end
    endtask

    task automatic test_write_read();
        @(negedge CLK);
        LE = 1; RW = 4'd5; PW = 32'd20;
        tick();
        idle_inputs();
        RA = 4'd5;
        #1;
        checks++; if (PA !== 32'd20) begin errors++; $display("FAIL wr_r5 got %h want %h", PA, 32'd20); end
        #1 RST = 1'b1;
        #2 RST = 1'b0;
        model_reset();
        #1;
        checks++; if (PA !== 32'd0) begin errors++; $display("FAIL rst_r5 got %h want 0", PA); end
    endtask

    task automatic test_banking();
        @(negedge CLK);
        MODE = 2'd0; LE = 1; RW = 4'd13; PW = 32'd100;
        tick();
        MODE = 2'd2; PW = 32'd200;
        tick();
        idle_inputs();
        RB = 4'd13;
        #1;
        checks++; if (PB !== 32'd200) begin errors++; $display("FAIL bank_svc got %0d want 200", PB); end
        MODE = 2'd0;
        #1;
        checks++; if (PB !== 32'd100) begin errors++; $display("FAIL bank_usr got %0d want 100", PB); end
        MODE = 2'd3;
        #1;
        checks++; if (PB !== 32'd0) begin errors++; $display("FAIL bank_abt got %0d want 0", PB); end
        MODE = 2'd0;
    endtask

    task automatic test_conflict_pc();
        @(negedge CLK);
        LE = 1; LE2 = 1; RW = 4'd7; RW2 = 4'd7; PW = 32'd11; PW2 = 32'd22;
        tick();
        idle_inputs();
        RA = 4'd7;
        #1;
        checks++; if (PA !== 32'd11) begin errors++; $display("FAIL conflict_r7 got %0d want 11", PA); end
        LE = 1; RW = 4'd15; PW = 32'd64;
        tick();
        idle_inputs();
        checks++; if (PC_LD !== 1'b1) begin errors++; $display("FAIL pcld_set got %b want 1", PC_LD); end
        checks++; if (PC_NEXT !== 32'd64) begin errors++; $display("FAIL pcnext got %0d want 64", PC_NEXT); end
        tick();
        checks++; if (PC_LD !== 1'b0) begin errors++; $display("FAIL pcld_clr got %b want 0", PC_LD); end
        checks++; if (PC_NEXT !== 32'd64) begin errors++; $display("FAIL pcnext_hold got %0d want 64", PC_NEXT); end
        RA = 4'd15; PROGCOUNT = 32'h1234;
        #1;
        checks++; if (PA !== 32'h1234) begin errors++; $display("FAIL read_pc got %h want %h", PA, 32'h1234); end
        // Port 1 PC write, then a back-to-back port 0 PC write.
        LE2 = 1; RW2 = 4'd15; PW2 = 32'd77;
        tick();
        checks++; if (PC_LD !== 1'b1 || PC_NEXT !== 32'd77) begin errors++; $display("FAIL pc_port1 got %b/%0d want 1/77", PC_LD, PC_NEXT); end
        idle_inputs();
        LE = 1; RW = 4'd15; PW = 32'd88;
        tick();
        checks++; if (PC_LD !== 1'b1 || PC_NEXT !== 32'd88) begin errors++; $display("FAIL pc_b2b got %b/%0d want 1/88", PC_LD, PC_NEXT); end
        idle_inputs();
        tick();
    endtask

    task automatic test_sweep();
        MODE = 2'd1;
        for (int i = 0; i < 15; i++) begin
            LE = 1; RW = 4'(i); PW = 32'(20 + i);
            RA = 4'(i); RB = 4'((i + 1) % 16); RC = 4'((i + 2) % 16);
            #1;
            checks++; if (PA !== model_read(RA)) begin errors++; $display("FAIL sweep_pre_pa i=%0d got %h want %h", i, PA, model_read(RA)); end
            checks++; if (PC !== model_read(RC)) begin errors++; $display("FAIL sweep_pre_pc i=%0d got %h want %h", i, PC, model_read(RC)); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            RA = 4'(i); RB = 4'((i + 1) % 16);
            #1;
            checks++; if (PA !== 32'(20 + i)) begin errors++; $display("FAIL sweep_rd i=%0d got %0d want %0d", i, PA, 20 + i); end
            checks++; if (PB !== model_read(RB)) begin errors++; $display("FAIL sweep_rdb i=%0d got %h want %h", i, PB, model_read(RB)); end
        end
        MODE = 2'd0; RA = 4'd13; RB = 4'd14;
        #1;
        checks++; if (PA !== 32'd100) begin errors++; $display("FAIL sweep_usr_r13 got %0d want 100", PA); end
        checks++; if (PB !== 32'd0) begin errors++; $display("FAIL sweep_usr_r14 got %0d want 0", PB); end
    endtask

    task automatic test_bypass();
        #1 RST = 1'b1;
        #2 RST = 1'b0;
        model_reset();
        @(negedge CLK);
        LE = 1; RW = 4'd9; RA = 4'd9; PW = 32'hDEAD;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        checks++; if (PA !== 32'hDEAD) begin errors++; $display("FAIL bypass_pre got %h want %h", PA, 32'hDEAD); end
`else
        checks++; if (PA !== 32'd0) begin errors++; $display("FAIL nobypass_pre got %h want 0", PA); end
`endif
        RC = 4'd15; PROGCOUNT = 32'h40; LE2 = 1; RW2 = 4'd15; PW2 = 32'h99;
        #1;
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL bypass_pcread got %h want %h", PC, 32'h40); end
        tick();
        idle_inputs();
        #1;
        checks++; if (PA !== 32'hDEAD) begin errors++; $display("FAIL bypass_post got %h want %h", PA, 32'hDEAD); end
        tick();
    endtask

    task automatic test_async_reset();
        LE = 1; RW = 4'd15; PW = 32'h55;
        tick();
        idle_inputs();
        checks++; if (PC_LD !== 1'b1) begin errors++; $display("FAIL ar_pre_pcld got %b want 1", PC_LD); end
        #1 RST = 1'b1;
        #1;
        checks++; if (PC_LD !== 1'b0 || PC_NEXT !== 32'd0) begin errors++; $display("FAIL ar_pc_clear got %b/%h want 0/0", PC_LD, PC_NEXT); end
        LE = 1; RW = 4'd3; PW = 32'd5; RA = 4'd3;
        @(posedge CLK);
        #2 RST = 1'b0;
        model_reset();
        idle_inputs();
        #1;
        checks++; if (PA !== 32'd0) begin errors++; $display("FAIL ar_write_lost got %h want 0", PA); end
    endtask

    task automatic test_random();
        @(negedge CLK);
        for (int c = 0; c < 400; c++) begin
            LE  = 1'($urandom_range(0, 1));
            LE2 = 1'($urandom_range(0, 1));
            RW  = 4'($urandom); RW2 = 4'($urandom);
            if ($urandom_range(0, 3) == 0) RW2 = RW;
            PW  = $urandom; PW2 = $urandom;
            RA  = 4'($urandom); RB = 4'($urandom); RC = 4'($urandom);
            MODE = 2'($urandom); PROGCOUNT = $urandom;
            #1;
            checks++; if (PA !== model_read(RA)) begin errors++; $display("FAIL rand_pa c=%0d ra=%0d got %h want %h", c, RA, PA, model_read(RA)); end
            checks++; if (PB !== model_read(RB)) begin errors++; $display("FAIL rand_pb c=%0d rb=%0d got %h want %h", c, RB, PB, model_read(RB)); end
            checks++; if (PC !== model_read(RC)) begin errors++; $display("FAIL rand_pc c=%0d rc=%0d got %h want %h", c, RC, PC, model_read(RC)); end
            tick();
            checks++; if (PC_LD !== m_pc_ld) begin errors++; $display("FAIL rand_pcld c=%0d got %b want %b", c, PC_LD, m_pc_ld); end
            checks++; if (PC_NEXT !== m_pc_next) begin errors++; $display("FAIL rand_pcnext c=%0d got %h want %h", c, PC_NEXT, m_pc_next); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_banking();
        test_conflict_pc();
        test_sweep();
        test_bypass();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
